riscv_pipe_regs: RTL and testbench
==================================

Name: riscv_pipe_regs

Overview:
- Pipeline-register datapath for the 5-stage RV32I core: PC register plus the F/D, D/E, E/M and M/W registers, and the E-stage operand forwarding muxes.
- It is the consumer of the hazard unit's stall, flush and forward controls.
- Sits between the fetch, decode, ALU, data-memory and writeback logic.
- Feeds the rd, rs and reg_write/result_src fields of each stage back to the hazard unit.

Parameters:
XLEN, 32, datapath width
RESET_PC, 32'h0000_0000, PC value after reset
CTRL_W, 8, width of the opaque D-stage control bundle (alu_ctrl, mem_write, branch, jump, alu_src, ...)

Ports:
i_clk  in  1  clock, all state updates on rising edge
i_rst  in  1  synchronous active-high reset
i_stall_f  in  1  hold PC
i_stall_d  in  1  hold F/D register
i_flush_d  in  1  clear F/D register to NOP
i_flush_e  in  1  clear D/E register to bubble
i_forward_a_e  in  2  src A select: 00 regfile, 01 W result, 10 M ALU result
i_forward_b_e  in  2  src B / store-data select, same encoding
i_pc_next_f  in  XLEN  next PC from fetch mux
o_pc_f  out  XLEN  current fetch PC
i_instr_f  in  32  fetched instruction
o_instr_d  out  32  D-stage instruction
o_pc_d  out  XLEN  D-stage PC
i_rs1_d, i_rs2_d, i_rd_d  in  5 each  decoded register indices
i_rd1_d, i_rd2_d  in  XLEN each  regfile read data
i_imm_d  in  XLEN  extended immediate
i_reg_write_d  in  1  D-stage writes rd
i_result_src_d  in  1  D-stage is a load
i_ctrl_d  in  CTRL_W  other D-stage controls
o_rs1_e, o_rs2_e, o_rd_e  out  5 each  E-stage indices (to hazard unit)
o_result_src_e, o_reg_write_e  out  1 each  E-stage load flag and write enable
o_ctrl_e, o_imm_e, o_pc_e  out  CTRL_W/XLEN/XLEN  E-stage controls and operands
o_src_a_e, o_write_data_e  out  XLEN each  forwarded rs1 and rs2 operands
i_alu_result_e  in  XLEN  ALU output
o_alu_result_m, o_write_data_m  out  XLEN each  M-stage address and store data
o_rd_m, o_reg_write_m, o_result_src_m  out  5/1/1  M-stage fields
i_read_data_m  in  XLEN  data-memory read data
o_rd_w, o_reg_write_w  out  5/1  W-stage fields
o_result_w  out  XLEN  writeback value

Behaviour:
- Reset (i_rst high at an edge) dominates everything, including mid-stall or mid-flush. Reset values:
  - o_pc_f = RESET_PC.
  - o_instr_d = 32'h0000_0013 (NOP).
  - All other registered outputs = 0, so o_reg_write_e/m/w = 0 and o_result_src_e/m = 0.
- PC:
  - i_stall_f=1: hold.
  - Otherwise load i_pc_next_f.
- F/D register, priority i_flush_d > i_stall_d > advance:
  - Flush: instr = NOP, pc = 0.
  - Stall: hold.
  - Advance: capture i_instr_f, o_pc_f.
- D/E register:
  - No stall input.
  - i_flush_e=1: bubble, i.e. reg_write=0, result_src=0, ctrl=0, rd/rs1/rs2=0, data fields=0.
  - Otherwise capture all D inputs.
- E/M and M/W registers:
  - Always advance.
  - M/W captures alu_result, read_data, rd, reg_write, result_src.
- Writeback mux (combinational in W): o_result_w = result_src_w ? read_data_w : alu_result_w.
- Forwarding (combinational in E):
  - o_src_a_e = mux(i_forward_a_e): rd1_e / o_result_w / o_alu_result_m.
  - o_write_data_e: same mux on rd2_e with i_forward_b_e.
  - Code 11 selects the regfile value.
- Latency: an instruction moves one stage per unstalled cycle. F to W is 4 cycles after fetch.
- Stall + flush on the same stage in the same cycle: flush wins. This cannot occur from a correct hazard unit, but behaviour is defined.
- A bubble from i_flush_e propagates through M and W with reg_write=0, so it never writes the regfile or forwards a usable match.

Test Plan:
- Reset: hold i_rst 2 cycles with random inputs -> o_pc_f=0, o_instr_d=32'h13, all reg_write/result_src=0; first post-reset edge loads i_pc_next_f=4.
- Straight line: issue addi x1 (rd=1, reg_write=1) with alu_result 5 -> o_rd_m=1 at cycle 3, o_result_w=5 and o_reg_write_w=1 at cycle 4.
- Load-use: assert i_stall_f, i_stall_d and i_flush_e for 1 cycle with F/D holding instr 0x00208133 and PC 0x10 -> PC and F/D unchanged, o_reg_write_e=0, o_rd_e=0 next cycle; resumes after.
- Branch taken: i_flush_d=1 and i_flush_e=1 with i_stall_d=1 also high -> o_instr_d=32'h13 (flush beats stall), E bubble, PC loads target 0x40.
- Forwarding: o_alu_result_m=0xAA, o_result_w=0x55, rd1_e=0x11 -> fwd_a 10/01/00/11 yields 0xAA/0x55/0x11/0x11. Result_src_w=1 with read_data 0x77 -> 01 yields 0x77.
- Reset mid-stall: i_stall_f=1 and i_rst=1 on the same edge -> o_pc_f=RESET_PC.

Source files
------------

// File: rtl/riscv_pipe_regs.sv
// riscv_pipe_regs: pipeline registers of the 5-stage RV32I core.
// Holds the PC and the F/D, D/E, E/M and M/W registers, the E-stage operand
// forwarding muxes and the W-stage result mux. Stall, flush and forward
// selects come from the hazard unit; the rd/rs/reg_write/result_src fields
// of every stage go back to it.
//
// Reset is synchronous, active high, and overrides stall and flush.
// Flush beats stall when both target the same register.
// A D/E bubble has reg_write=0 and rd=0. It therefore never writes the
// regfile and never forwards a usable match as it drains through M and W.

module riscv_pipe_regs #(
   parameter int unsigned      XLEN     = 32,
   parameter logic [XLEN-1:0]  RESET_PC = '0,
   parameter int unsigned      CTRL_W   = 8
) (
   input  logic              i_clk,
   input  logic              i_rst,

   // hazard unit controls
   input  logic              i_stall_f,
   input  logic              i_stall_d,
   input  logic              i_flush_d,
   input  logic              i_flush_e,
   input  logic [1:0]        i_forward_a_e,
   input  logic [1:0]        i_forward_b_e,

   // fetch
   input  logic [XLEN-1:0]   i_pc_next_f,
   output logic [XLEN-1:0]   o_pc_f,
   input  logic [31:0]       i_instr_f,

   // decode
   output logic [31:0]       o_instr_d,
   output logic [XLEN-1:0]   o_pc_d,
   input  logic [4:0]        i_rs1_d,
   input  logic [4:0]        i_rs2_d,
   input  logic [4:0]        i_rd_d,
   input  logic [XLEN-1:0]   i_rd1_d,
   input  logic [XLEN-1:0]   i_rd2_d,
   input  logic [XLEN-1:0]   i_imm_d,
   input  logic              i_reg_write_d,
   input  logic              i_result_src_d,
   input  logic [CTRL_W-1:0] i_ctrl_d,

   // execute
   output logic [4:0]        o_rs1_e,
   output logic [4:0]        o_rs2_e,
   output logic [4:0]        o_rd_e,
   output logic              o_result_src_e,
   output logic              o_reg_write_e,
   output logic [CTRL_W-1:0] o_ctrl_e,
   output logic [XLEN-1:0]   o_imm_e,
   output logic [XLEN-1:0]   o_pc_e,
   output logic [XLEN-1:0]   o_src_a_e,
   output logic [XLEN-1:0]   o_write_data_e,
   input  logic [XLEN-1:0]   i_alu_result_e,

   // memory
   output logic [XLEN-1:0]   o_alu_result_m,
   output logic [XLEN-1:0]   o_write_data_m,
   output logic [4:0]        o_rd_m,
   output logic              o_reg_write_m,
   output logic              o_result_src_m,
   input  logic [XLEN-1:0]   i_read_data_m,

   // writeback
   output logic [4:0]        o_rd_w,
   output logic              o_reg_write_w,
   output logic [XLEN-1:0]   o_result_w
);

   // addi x0, x0, 0: the canonical RV32I NOP
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // forwarding select encoding (11 falls back to the regfile)
   localparam logic [1:0] FWD_RF = 2'b00;
   localparam logic [1:0] FWD_W  = 2'b01;
   localparam logic [1:0] FWD_M  = 2'b10;

   // D/E operand values: only reach the outside through the forwarding muxes
   logic [XLEN-1:0] rd1_e;
   logic [XLEN-1:0] rd2_e;

   // M/W data-path fields feeding the result mux
   logic [XLEN-1:0] alu_result_w;
   logic [XLEN-1:0] read_data_w;
   logic            result_src_w;

   // PC register: hold while fetch is stalled
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_pc_f <= RESET_PC;
      end else if (!i_stall_f) begin
         o_pc_f <= i_pc_next_f;
      end
   end

   // F/D register: flush to NOP, otherwise hold on stall, otherwise advance
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_instr_d <= NOP_INSTR;
         o_pc_d    <= '0;
      end else if (i_flush_d) begin
         o_instr_d <= NOP_INSTR;
         o_pc_d    <= '0;
      end else if (!i_stall_d) begin
         o_instr_d <= i_instr_f;
         o_pc_d    <= o_pc_f;
      end
   end

   // D/E register: a flush inserts an all-zero bubble, otherwise capture decode
   always_ff @(posedge i_clk) begin
      if (i_rst || i_flush_e) begin
         o_rs1_e        <= '0;
         o_rs2_e        <= '0;
         o_rd_e         <= '0;
         rd1_e          <= '0;
         rd2_e          <= '0;
         o_imm_e        <= '0;
         o_pc_e         <= '0;
         o_ctrl_e       <= '0;
         o_reg_write_e  <= 1'b0;
         o_result_src_e <= 1'b0;
      end else begin
         o_rs1_e        <= i_rs1_d;
         o_rs2_e        <= i_rs2_d;
         o_rd_e         <= i_rd_d;
         rd1_e          <= i_rd1_d;
         rd2_e          <= i_rd2_d;
         o_imm_e        <= i_imm_d;
         o_pc_e         <= o_pc_d;
         o_ctrl_e       <= i_ctrl_d;
         o_reg_write_e  <= i_reg_write_d;
         o_result_src_e <= i_result_src_d;
      end
   end

   // source A forwarding: regfile, W result or M ALU result
   always_comb begin
      o_src_a_e = rd1_e;
      case (i_forward_a_e)
         FWD_W:   o_src_a_e = o_result_w;
         FWD_M:   o_src_a_e = o_alu_result_m;
         FWD_RF:  o_src_a_e = rd1_e;
         default: o_src_a_e = rd1_e;
      endcase
   end

   // source B / store-data forwarding, same encoding as source A
   always_comb begin
      o_write_data_e = rd2_e;
      case (i_forward_b_e)
         FWD_W:   o_write_data_e = o_result_w;
         FWD_M:   o_write_data_e = o_alu_result_m;
         FWD_RF:  o_write_data_e = rd2_e;
         default: o_write_data_e = rd2_e;
      endcase
   end

   // E/M register: always advances; store data is the forwarded rs2 value
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_alu_result_m <= '0;
         o_write_data_m <= '0;
         o_rd_m         <= '0;
         o_reg_write_m  <= 1'b0;
         o_result_src_m <= 1'b0;
      end else begin
         o_alu_result_m <= i_alu_result_e;
         o_write_data_m <= o_write_data_e;
         o_rd_m         <= o_rd_e;
         o_reg_write_m  <= o_reg_write_e;
         o_result_src_m <= o_result_src_e;
      end
   end

   // M/W register: always advances
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         alu_result_w  <= '0;
         read_data_w   <= '0;
         o_rd_w        <= '0;
         o_reg_write_w <= 1'b0;
         result_src_w  <= 1'b0;
      end else begin
         alu_result_w  <= o_alu_result_m;
         read_data_w   <= i_read_data_m;
         o_rd_w        <= o_rd_m;
         o_reg_write_w <= o_reg_write_m;
         result_src_w  <= o_result_src_m;
      end
   end

   // writeback mux: loads return memory data, everything else the ALU result
   always_comb begin
      o_result_w = result_src_w ? read_data_w : alu_result_w;
   end

endmodule

// File: tb/tb_riscv_pipe_regs.sv
// tb_riscv_pipe_regs: directed test of the pipeline-register datapath.
// Inputs change 1 ns after the rising edge, and registered outputs are sampled
// at the same point. Combinational paths are sampled 1 ns after their inputs move.

module tb_riscv_pipe_regs;

   localparam int XLEN   = 32;
   localparam int CTRL_W = 8;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic              clk;
   logic              rst;
   logic              stall_f, stall_d, flush_d, flush_e;
   logic [1:0]        forward_a_e, forward_b_e;
   logic [XLEN-1:0]   pc_next_f, pc_f;
   logic [31:0]       instr_f, instr_d;
   logic [XLEN-1:0]   pc_d;
   logic [4:0]        rs1_d, rs2_d, rd_d;
   logic [XLEN-1:0]   rd1_d, rd2_d, imm_d;
   logic              reg_write_d, result_src_d;
   logic [CTRL_W-1:0] ctrl_d;
   logic [4:0]        rs1_e, rs2_e, rd_e;
   logic              result_src_e, reg_write_e;
   logic [CTRL_W-1:0] ctrl_e;
   logic [XLEN-1:0]   imm_e, pc_e, src_a_e, write_data_e, alu_result_e;
   logic [XLEN-1:0]   alu_result_m, write_data_m;
   logic [4:0]        rd_m;
   logic              reg_write_m, result_src_m;
   logic [XLEN-1:0]   read_data_m;
   logic [4:0]        rd_w;
   logic              reg_write_w;
   logic [XLEN-1:0]   result_w;

   int checks   = 0;
   int failures = 0;

   // scoreboard: writeback values expected, in order
   logic [XLEN-1:0] exp_q[$];

   riscv_pipe_regs #(.XLEN(XLEN), .RESET_PC(32'h0000_0000), .CTRL_W(CTRL_W)) dut (
      .i_clk(clk), .i_rst(rst),
      .i_stall_f(stall_f), .i_stall_d(stall_d), .i_flush_d(flush_d), .i_flush_e(flush_e),
      .i_forward_a_e(forward_a_e), .i_forward_b_e(forward_b_e),
      .i_pc_next_f(pc_next_f), .o_pc_f(pc_f), .i_instr_f(instr_f),
      .o_instr_d(instr_d), .o_pc_d(pc_d),
      .i_rs1_d(rs1_d), .i_rs2_d(rs2_d), .i_rd_d(rd_d),
      .i_rd1_d(rd1_d), .i_rd2_d(rd2_d), .i_imm_d(imm_d),
      .i_reg_write_d(reg_write_d), .i_result_src_d(result_src_d), .i_ctrl_d(ctrl_d),
      .o_rs1_e(rs1_e), .o_rs2_e(rs2_e), .o_rd_e(rd_e),
      .o_result_src_e(result_src_e), .o_reg_write_e(reg_write_e),
      .o_ctrl_e(ctrl_e), .o_imm_e(imm_e), .o_pc_e(pc_e),
      .o_src_a_e(src_a_e), .o_write_data_e(write_data_e), .i_alu_result_e(alu_result_e),
      .o_alu_result_m(alu_result_m), .o_write_data_m(write_data_m),
      .o_rd_m(rd_m), .o_reg_write_m(reg_write_m), .o_result_src_m(result_src_m),
      .i_read_data_m(read_data_m),
      .o_rd_w(rd_w), .o_reg_write_w(reg_write_w), .o_result_w(result_w)
   );

   // clock and watchdog
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
      end
   endtask

   // advance one clock; the scoreboard consumes every regfile write seen in W
   task automatic step();
      logic [XLEN-1:0] exp;
      @(posedge clk);
      #1;
      if (reg_write_w === 1'b1) begin
         check_val("wb_expected", 32'(exp_q.size() > 0), 32'd1);
         if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check_val("wb_result", result_w, exp);
         end
      end
   endtask

   task automatic clear_d();
      rs1_d = '0; rs2_d = '0; rd_d = '0;
      rd1_d = '0; rd2_d = '0; imm_d = '0;
      reg_write_d = 1'b0; result_src_d = 1'b0; ctrl_d = '0;
   endtask

   task automatic clear_ctrl();
      stall_f = 1'b0; stall_d = 1'b0; flush_d = 1'b0; flush_e = 1'b0;
      forward_a_e = 2'b00; forward_b_e = 2'b00;
   endtask

   task automatic randomize_inputs();
      stall_f = 1'($urandom_range(1)); stall_d = 1'($urandom_range(1));
      flush_d = 1'($urandom_range(1)); flush_e = 1'($urandom_range(1));
      forward_a_e = 2'($urandom_range(3)); forward_b_e = 2'($urandom_range(3));
      pc_next_f = $urandom; instr_f = $urandom;
      rs1_d = 5'($urandom_range(31)); rs2_d = 5'($urandom_range(31)); rd_d = 5'($urandom_range(31));
      rd1_d = $urandom; rd2_d = $urandom; imm_d = $urandom;
      reg_write_d = 1'b1; result_src_d = 1'b1; ctrl_d = 8'($urandom_range(255));
      alu_result_e = $urandom; read_data_m = $urandom;
   endtask

   logic [1:0]  fwd_code [4];
   logic [31:0] fwd_exp_a [4];
   logic [31:0] fwd_exp_b [4];

   initial begin
      // ---------------- reset with random inputs ----------------
      rst = 1'b1;
      randomize_inputs();
      step();
      randomize_inputs();
      step();
      check_val("rst_pc_f", pc_f, 32'h0);
      check_val("rst_instr_d", instr_d, NOP);
      check_val("rst_pc_d", pc_d, 32'h0);
      check_val("rst_reg_write_e", 32'(reg_write_e), 32'h0);
      check_val("rst_reg_write_m", 32'(reg_write_m), 32'h0);
      check_val("rst_reg_write_w", 32'(reg_write_w), 32'h0);
      check_val("rst_result_src_e", 32'(result_src_e), 32'h0);
      check_val("rst_result_src_m", 32'(result_src_m), 32'h0);
      check_val("rst_rd_e", 32'(rd_e), 32'h0);

      rst = 1'b0;
      clear_ctrl();
      clear_d();
      alu_result_e = '0; read_data_m = '0;
      instr_f = NOP;
      pc_next_f = 32'h4;
      step();
      check_val("post_rst_pc_f", pc_f, 32'h4);

      // ---------------- straight line: addi x1, x0, 5 ----------------
      instr_f = 32'h0050_0093;
      pc_next_f = 32'h8;
      step();
      check_val("sl_instr_d", instr_d, 32'h0050_0093);
      check_val("sl_pc_d", pc_d, 32'h4);
      instr_f = NOP; pc_next_f = 32'hC;
      rd_d = 5'd1; imm_d = 32'd5; reg_write_d = 1'b1; ctrl_d = 8'h01;
      exp_q.push_back(32'd5);
      step();
      check_val("sl_rd_e", 32'(rd_e), 32'd1);
      check_val("sl_reg_write_e", 32'(reg_write_e), 32'd1);
      check_val("sl_imm_e", imm_e, 32'd5);
      check_val("sl_pc_e", pc_e, 32'h4);
      check_val("sl_ctrl_e", 32'(ctrl_e), 32'h01);
      clear_d();
      alu_result_e = 32'd5;
      step();
      check_val("sl_rd_m", 32'(rd_m), 32'd1);
      check_val("sl_alu_m", alu_result_m, 32'd5);
      alu_result_e = '0;
      step();
      check_val("sl_rd_w", 32'(rd_w), 32'd1);
      check_val("sl_reg_write_w", 32'(reg_write_w), 32'd1);
      check_val("sl_result_w", result_w, 32'd5);

      // ---------------- load-use stall ----------------
      pc_next_f = 32'h10;
      step();
      instr_f = 32'h0020_8133; pc_next_f = 32'h14;
      step();
      check_val("lu_pre_instr_d", instr_d, 32'h0020_8133);
      check_val("lu_pre_pc_d", pc_d, 32'h10);
      stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
      instr_f = 32'h0000_0033; pc_next_f = 32'h18;
      rs1_d = 5'd1; rs2_d = 5'd2; rd_d = 5'd2; reg_write_d = 1'b1;
      step();
      check_val("lu_pc_hold", pc_f, 32'h14);
      check_val("lu_instr_hold", instr_d, 32'h0020_8133);
      check_val("lu_pc_d_hold", pc_d, 32'h10);
      check_val("lu_bubble_reg_write_e", 32'(reg_write_e), 32'h0);
      check_val("lu_bubble_rd_e", 32'(rd_e), 32'h0);
      check_val("lu_bubble_rs1_e", 32'(rs1_e), 32'h0);
      clear_ctrl();
      step();
      check_val("lu_resume_pc_f", pc_f, 32'h18);
      check_val("lu_resume_instr_d", instr_d, 32'h0000_0033);
      check_val("lu_resume_rd_e", 32'(rd_e), 32'd2);
      check_val("lu_resume_reg_write_e", 32'(reg_write_e), 32'd1);
      check_val("lu_bubble_reg_write_m", 32'(reg_write_m), 32'h0);
      clear_d();
      alu_result_e = 32'h33;
      exp_q.push_back(32'h33);
      step();
      alu_result_e = '0;
      step();
      check_val("lu_rd_w", 32'(rd_w), 32'd2);

      // ---------------- taken branch: flush beats stall ----------------
      instr_f = 32'h1234_5678; pc_next_f = 32'h1C;
      step();
      check_val("br_pre_instr_d", instr_d, 32'h1234_5678);
      flush_d = 1'b1; flush_e = 1'b1; stall_d = 1'b1;
      pc_next_f = 32'h40;
      rd_d = 5'd3; reg_write_d = 1'b1; result_src_d = 1'b1; imm_d = 32'h99;
      step();
      check_val("br_instr_d", instr_d, NOP);
      check_val("br_pc_d", pc_d, 32'h0);
      check_val("br_pc_f", pc_f, 32'h40);
      check_val("br_reg_write_e", 32'(reg_write_e), 32'h0);
      check_val("br_result_src_e", 32'(result_src_e), 32'h0);
      check_val("br_rd_e", 32'(rd_e), 32'h0);
      check_val("br_imm_e", imm_e, 32'h0);
      clear_ctrl();
      clear_d();
      instr_f = NOP; pc_next_f = 32'h44;
      step();
      check_val("br_bubble_reg_write_m", 32'(reg_write_m), 32'h0);

      // ---------------- forwarding muxes ----------------
      alu_result_e = 32'h55;
      step();
      alu_result_e = 32'hAA;
      rd1_d = 32'h11; rd2_d = 32'h22;
      step();
      fwd_code[0] = 2'b10; fwd_exp_a[0] = 32'hAA; fwd_exp_b[0] = 32'hAA;
      fwd_code[1] = 2'b01; fwd_exp_a[1] = 32'h55; fwd_exp_b[1] = 32'h55;
      fwd_code[2] = 2'b00; fwd_exp_a[2] = 32'h11; fwd_exp_b[2] = 32'h22;
      fwd_code[3] = 2'b11; fwd_exp_a[3] = 32'h11; fwd_exp_b[3] = 32'h22;
      for (int i = 0; i < 4; i++) begin
         forward_a_e = fwd_code[i];
         forward_b_e = fwd_code[i];
         #1;
         check_val($sformatf("fwd_a_%0d", i), src_a_e, fwd_exp_a[i]);
         check_val($sformatf("fwd_b_%0d", i), write_data_e, fwd_exp_b[i]);
      end
      forward_a_e = 2'b00; forward_b_e = 2'b00;

      // ---------------- load through W, forwarded from read data ----------------
      rd_d = 5'd5; reg_write_d = 1'b1; result_src_d = 1'b1;
      rd1_d = 32'h11; rd2_d = 32'h22;
      alu_result_e = 32'h0;
      exp_q.push_back(32'h77);
      step();
      check_val("ld_result_src_e", 32'(result_src_e), 32'd1);
      rd_d = '0; reg_write_d = 1'b0; result_src_d = 1'b0;
      alu_result_e = 32'h100;
      step();
      check_val("ld_result_src_m", 32'(result_src_m), 32'd1);
      check_val("ld_write_data_m", write_data_m, 32'h22);
      check_val("ld_alu_m", alu_result_m, 32'h100);
      alu_result_e = '0;
      read_data_m = 32'h77;
      step();
      read_data_m = '0;
      check_val("ld_rd_w", 32'(rd_w), 32'd5);
      forward_a_e = 2'b01;
      #1;
      check_val("ld_fwd_a_w", src_a_e, 32'h77);
      forward_a_e = 2'b00;

      // ---------------- reset while fetch is stalled ----------------
      pc_next_f = 32'h80;
      step();
      check_val("rs_pre_pc_f", pc_f, 32'h80);
      stall_f = 1'b1; rst = 1'b1; pc_next_f = 32'h90;
      step();
      check_val("rs_pc_f", pc_f, 32'h0);
      check_val("rs_instr_d", instr_d, NOP);
      check_val("rs_reg_write_w", 32'(reg_write_w), 32'h0);
      rst = 1'b0; stall_f = 1'b0;

      check_val("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
